// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: single-clock parametrised FIFO with an exact occupancy count,
// programmable almost-full / almost-empty thresholds, and a compile-time
// choice between a registered read port and first-word-fall-through output.
//
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN
//   When defined, adds the sticky overflow/underflow error flags and the
//   err_clr input that clears them. When undefined, those ports and their
//   logic do not exist.
//
// Status flags are all registered from the next-state count, so count,
// full, empty and the almost flags always change together on one edge.

module sync_fifo_pro #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Count/pointer constants at full ADDR_WIDTH+1 width.
    localparam logic [ADDR_WIDTH:0] ZERO_C  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Storage and state.
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_r;
    logic [ADDR_WIDTH:0]   rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;

    // Next-state terms.
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [ADDR_WIDTH:0]   count_next_s;
    logic                  full_next_s;
    logic                  empty_next_s;
    logic                  almost_full_next_s;
    logic                  almost_empty_next_s;

    // Requests against a full/empty FIFO are dropped; acceptance is judged on
    // the current registered flags, so full+wr+rd pops only and
    // empty+wr+rd pushes only.
    always_comb begin
        wr_acc_s = wr_en & ~full_r;
        rd_acc_s = rd_en & ~empty_r;
    end

    // Occupancy after this edge: +1 on a lone write, -1 on a lone read.
    always_comb begin
        count_next_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Flag next-state derived from the next count and the live thresholds.
    always_comb begin
        full_next_s         = (count_next_s == DEPTH_C);
        empty_next_s        = (count_next_s == ZERO_C);
        almost_empty_next_s = (count_next_s <= ae_thresh);
        if (af_thresh != ZERO_C) begin
            almost_full_next_s = (count_next_s >= af_thresh);
        end else begin
            almost_full_next_s = 1'b0;
        end
    end

    // Accepted writes land in memory; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Pointers advance on accepted operations and wrap modulo 2**(ADDR_WIDTH+1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
        end
    end

    // Count and status flags register together so they are always coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r        <= ZERO_C;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            count_r        <= count_next_s;
            full_r         <= full_next_s;
            empty_r        <= empty_next_s;
            almost_full_r  <= almost_full_next_s;
            almost_empty_r <= almost_empty_next_s;
        end
    end

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;

    generate
        if (FWFT_MODE != 0) begin : g_fwft
            // Head word is always presented through an asynchronous array read;
            // a pop simply moves rd_ptr so the next word appears combinationally.
            assign rd_data  = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
            assign rd_valid = ~empty_r;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_r;
            logic                  rd_valid_r;

            // Registered read: data and a one-cycle valid follow each accepted pop;
            // rd_data holds its last value between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_r  <= {DATA_WIDTH{1'b0}};
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_valid_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        rd_data_r <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
                    end
                end
            end

            assign rd_data  = rd_data_r;
            assign rd_valid = rd_valid_r;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags: set by a rejected write/read, cleared by err_clr,
    // with the clear winning over a set on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (err_clr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en & full_r) begin
                overflow_r <= 1'b1;
            end
            if (rd_en & empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`endif

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Directed bench for sync_fifo_pro. A reference queue tracks stored words;
// every accepted pop pushes the expected word into a scoreboard queue, and a
// separate monitor pops and compares whenever the standard-mode DUT asserts
// rd_valid. A second instance exercises first-word-fall-through mode.

module tb_sync_fifo_pro;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [DW-1:0] wr_data;
    logic [AW:0]   af_t, ae_t;
    logic [DW-1:0] rd_data;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]   count;

    logic          f_wr_en, f_rd_en;
    logic [DW-1:0] f_wr_data;
    logic [DW-1:0] f_rd_data;
    logic          f_rd_valid, f_full, f_empty, f_af, f_ae;
    logic [AW:0]   f_count;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          err_clr;
    logic          overflow, underflow;
    logic          f_overflow, f_underflow;
`endif

    int tests  = 0;
    int fails  = 0;

    logic [DW-1:0] mq[$];     // words currently stored in the reference model
    logic [DW-1:0] exp_q[$];  // words the standard DUT must still present
    logic          exp_rv;

    sync_fifo_pro #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT_MODE(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .af_thresh(af_t), .ae_thresh(ae_t),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
    );

    sync_fifo_pro #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT_MODE(1)) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .af_thresh(af_t), .ae_thresh(ae_t),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .err_clr(err_clr), .overflow(f_overflow), .underflow(f_underflow),
`endif
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every rd_valid cycle must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_data_unexpected: actual=0x%02h required=no valid", rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    fails++;
                    $display("FAIL rd_data: actual=0x%02h required=0x%02h", rd_data, e);
                end
            end
        end
    end

    // One clock of stimulus on the standard DUT, then compare count and flags
    // with the reference queue.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        bit wacc, racc;
        int cnt;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        wacc = w && (mq.size() != DEPTH);
        racc = r && (mq.size() != 0);
        @(posedge clk);
        if (racc) exp_q.push_back(mq.pop_front());
        if (wacc) mq.push_back(d);
        exp_rv = racc;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        cnt = mq.size();
        chk("count", int'(count), cnt);
        chk("full", int'(full), int'(cnt == DEPTH));
        chk("empty", int'(empty), int'(cnt == 0));
        chk("almost_full", int'(almost_full), int'((af_t != 0) && (cnt >= int'(af_t))));
        chk("almost_empty", int'(almost_empty), int'(cnt <= int'(ae_t)));
        chk("rd_valid", int'(rd_valid), int'(exp_rv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;
        af_t = 5'd14; ae_t = 5'd2; exp_rv = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        @(negedge clk);
        rst = 1'b0;

        // Fill 0x00..0x0F, then a 17th write that must be ignored.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
        chk("fill_full", int'(full), 1);
        cycle(1'b1, 8'hEE, 1'b0);
        chk("write_when_full_count", int'(count), 16);

        // Drain 16 words, then an extra pop on empty.
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("drained_empty", int'(empty), 1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("extra_rd_valid", int'(rd_valid), 0);

        // Prefill 8, stream 24 simultaneous wr/rd across the pointer wrap, drain.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 8'(8'h28 + i), 1'b1);
            chk("stream_count", int'(count), 8);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

        // Full + wr + rd: the read is taken and the written word dropped.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        cycle(1'b1, 8'h99, 1'b1);
        chk("full_wr_rd_count", int'(count), 15);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);

        // Empty + wr + rd: only the write is taken.
        cycle(1'b1, 8'h77, 1'b1);
        chk("empty_wr_rd_count", int'(count), 1);
        chk("empty_wr_rd_valid", int'(rd_valid), 0);
        cycle(1'b0, 8'h00, 1'b1);

        // Threshold extremes: af=0 disables, ae>=DEPTH keeps almost_empty high.
        af_t = 5'd0; ae_t = 5'd16;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        chk("af_disabled_at_full", int'(almost_full), 0);
        chk("ae_always_at_full", int'(almost_empty), 1);
        af_t = 5'd17;
        cycle(1'b0, 8'h00, 1'b0);
        chk("af_above_depth", int'(almost_full), 0);
        af_t = 5'd14; ae_t = 5'd2;
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        err_clr = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        err_clr = 1'b0;
        chk("err_clr_underflow", int'(underflow), 0);
`endif
        // Overflow behaviour, then reset asserted mid-stream at count 9.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        cycle(1'b1, 8'hDD, 1'b0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow_set", int'(overflow), 1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("overflow_held", int'(overflow), 1);
        err_clr = 1'b1;
        cycle(1'b1, 8'hDD, 1'b0);
        err_clr = 1'b0;
        chk("overflow_clr_priority", int'(overflow), 0);
        cycle(1'b1, 8'hDD, 1'b0);
        chk("overflow_reset", int'(overflow), 1);
`endif
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("pre_rst_count", int'(count), 9);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_full", int'(full), 0);
        chk("async_rst_ae", int'(almost_empty), 1);
        chk("async_rst_rd_valid", int'(rd_valid), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("async_rst_overflow", int'(overflow), 0);
`endif
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);

        // First-word-fall-through instance.
        @(negedge clk);
        chk("fwft_rst_empty", int'(f_empty), 1);
        chk("fwft_rst_valid", int'(f_rd_valid), 0);
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fwft_empty", int'(f_empty), 0);
        chk("fwft_valid", int'(f_rd_valid), 1);
        chk("fwft_data", int'(f_rd_data), 8'hA5);
        f_wr_en = 1'b1; f_wr_data = 8'h3C;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        chk("fwft_head_held", int'(f_rd_data), 8'hA5);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        chk("fwft_next_word", int'(f_rd_data), 8'h3C);
        chk("fwft_count1", int'(f_count), 1);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        chk("fwft_empty_after_pop", int'(f_empty), 1);
        chk("fwft_valid_after_pop", int'(f_rd_valid), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
